// File: rtl/pipe_bridge_pkg.sv
// Shared types and next-state logic for the pipe_bridge_skid stage register.
package pipe_bridge_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    // flush outranks every handshake; rst is applied by the caller's register.
    function automatic state_t next_state(
        input state_t cur,
        input logic   flush,
        input logic   in_fire,
        input logic   out_ready
    );
        state_t nxt;
        nxt = cur;
        if (flush) begin
            nxt = EMPTY;
        end else begin
            case (cur)
                EMPTY: if (in_fire) nxt = FULL;
                FULL: begin
                    if (in_fire && !out_ready)      nxt = SKID;
                    else if (!in_fire && out_ready) nxt = EMPTY;
                end
                SKID:    if (out_ready) nxt = FULL;
                default: nxt = EMPTY;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pipe_bridge_skid_sync_reset_reg.sv
// Sync-reset, load-enabled register used for the main and skid entries.
module sync_reset_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/pipe_bridge_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer and registered in_ready.
// Optional stall/bubble counters are built when PIPE_BRIDGE_PERF_EN is defined.
//
//  state | meaning
//  EMPTY | no entry held, out_valid=0, in_ready=1
//  FULL  | main register holds the output entry, in_ready=1
//  SKID  | main holds output, skid holds the next entry, in_ready=0
module pipe_bridge_skid
    import pipe_bridge_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CW    = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [CW-1:0]    in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CW-1:0]    out_ctrl,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    state_t state_q;
    state_t state_d;
    logic   in_ready_q;
    logic   in_fire;
    logic   main_load;
    logic   skid_load;
    logic   main_from_skid;

    logic [DW+CW-1:0] main_d;
    logic [DW+CW-1:0] main_q;
    logic [DW+CW-1:0] skid_q;

    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_valid = (state_q != EMPTY);

    always_comb begin
        state_d        = next_state(state_q, flush, in_fire, out_ready);
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: main_load = in_fire;
                FULL: begin
                    main_load = in_fire & out_ready;
                    skid_load = in_fire & ~out_ready;
                end
                SKID: begin
                    main_load      = out_ready;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : {in_data, in_ctrl};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID);
        end
    end

    sync_reset_reg #(.W(DW + CW)) u_main_reg (
        .clk (clk),
        .rst (rst),
        .en  (main_load),
        .d   (main_d),
        .q   (main_q)
    );

    sync_reset_reg #(.W(DW + CW)) u_skid_reg (
        .clk (clk),
        .rst (rst),
        .en  (skid_load),
        .d   ({in_data, in_ctrl}),
        .q   (skid_q)
    );

    // Data is held across bubbles; only control is gated so a bubble can never act.
    assign out_data = main_q[DW+CW-1:CW];
    assign out_ctrl = main_q[CW-1:0] & {CW{out_valid}};

`ifdef PIPE_BRIDGE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
            if (!out_valid && out_ready && (bubble_q != {CNT_W{1'b1}}))
                bubble_q <= bubble_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_bridge_skid.sv
// Directed bench for pipe_bridge_skid: streaming, skid, flush, reset and counters.
module tb_pipe_bridge_skid;

`ifdef PIPE_BRIDGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_data, stall_cnt, bubble_cnt;
    logic [7:0]  out_ctrl;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [7:0]  s_out_ctrl;
    logic [2:0]  s_stall_cnt, s_bubble_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_bridge_skid #(.DW(32), .CW(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_bridge_skid #(.DW(32), .CW(8), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total += 6;
        if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        if (out_data !== 32'h0)   begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        if (out_ctrl !== 8'h0)    begin bad++; $display("FAIL reset_out_ctrl got=%h want=0", out_ctrl); end
        if (stall_cnt !== 32'h0)  begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
        if (bubble_cnt !== 32'h0) begin bad++; $display("FAIL reset_bubble got=%0d want=0", bubble_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] d [3] = '{32'h100, 32'h104, 32'h108};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = d[i]; in_ctrl = 8'(i + 1);
            tick();
            total += 4;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b want=1", i, out_valid); end
            if (out_data !== d[i])  begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", i, out_data, d[i]); end
            if (out_ctrl !== 8'(i + 1)) begin bad++; $display("FAIL stream_ctrl[%0d] got=%h want=%h", i, out_ctrl, 8'(i + 1)); end
            if (in_ready !== 1'b1)  begin bad++; $display("FAIL stream_ready[%0d] got=%0b want=1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%0b want=0", out_valid); end
        if (out_ctrl !== 8'h0)  begin bad++; $display("FAIL stream_drain_ctrl got=%h want=0", out_ctrl); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA0; in_ctrl = 8'h11;
        tick();
        in_data = 32'hB0; in_ctrl = 8'h22;
        tick();
        total += 3;
        if (in_ready !== 1'b0)     begin bad++; $display("FAIL skid_in_ready got=%0b want=0", in_ready); end
        if (out_data !== 32'hA0)   begin bad++; $display("FAIL skid_head got=%h want=a0", out_data); end
        if (out_ctrl !== 8'h11)    begin bad++; $display("FAIL skid_head_ctrl got=%h want=11", out_ctrl); end
        // C offered while in_ready=0 must be ignored
        in_data = 32'hC0; in_ctrl = 8'h33; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total += 4;
        if (out_valid !== 1'b1)    begin bad++; $display("FAIL skid_second_valid got=%0b want=1", out_valid); end
        if (out_data !== 32'hB0)   begin bad++; $display("FAIL skid_second got=%h want=b0", out_data); end
        if (out_ctrl !== 8'h22)    begin bad++; $display("FAIL skid_second_ctrl got=%h want=22", out_ctrl); end
        if (in_ready !== 1'b1)     begin bad++; $display("FAIL skid_ready_back got=%0b want=1", in_ready); end
        tick();
        total += 2;
        if (out_valid !== 1'b0)    begin bad++; $display("FAIL skid_no_c_valid got=%0b want=0", out_valid); end
        if (out_data !== 32'hB0)   begin bad++; $display("FAIL skid_no_c_data got=%h want=b0", out_data); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA1; in_ctrl = 8'hFF;
        tick();
        in_data = 32'hB1;
        tick();
        total += 1;
        if (out_ctrl !== 8'hFF) begin bad++; $display("FAIL flush_pre_ctrl got=%h want=ff", out_ctrl); end
        flush = 1'b1; in_data = 32'hC1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total += 4;
        if (out_valid !== 1'b0)  begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
        if (out_ctrl !== 8'h0)   begin bad++; $display("FAIL flush_ctrl got=%h want=0", out_ctrl); end
        if (in_ready !== 1'b1)   begin bad++; $display("FAIL flush_ready got=%0b want=1", in_ready); end
        if (out_data !== 32'hA1) begin bad++; $display("FAIL flush_data_held got=%h want=a1", out_data); end
        out_ready = 1'b1;
        tick();
        total += 1;
        if (out_valid !== 1'b0)  begin bad++; $display("FAIL flush_c_absent got=%0b want=0", out_valid); end
    endtask

    task automatic test_counters();
        do_reset();
        in_valid = 1'b1; in_data = 32'hD0; in_ctrl = 8'h44;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        total += 4;
        if (stall_cnt !== (PERF ? 32'd5 : 32'd0)) begin bad++; $display("FAIL stall5 got=%0d want=%0d", stall_cnt, PERF ? 5 : 0); end
        if (s_stall_cnt !== (PERF ? 3'd5 : 3'd0)) begin bad++; $display("FAIL sat_stall5 got=%0d want=%0d", s_stall_cnt, PERF ? 5 : 0); end
        if (s_out_data !== 32'hD0) begin bad++; $display("FAIL sat_data got=%h want=d0", s_out_data); end
        if (out_data !== 32'hD0)   begin bad++; $display("FAIL stall_data got=%h want=d0", out_data); end
        repeat (5) tick();
        total += 2;
        if (stall_cnt !== (PERF ? 32'd10 : 32'd0)) begin bad++; $display("FAIL stall10 got=%0d want=%0d", stall_cnt, PERF ? 10 : 0); end
        if (s_stall_cnt !== (PERF ? 3'd7 : 3'd0))  begin bad++; $display("FAIL sat_stall10 got=%0d want=%0d", s_stall_cnt, PERF ? 7 : 0); end
        out_ready = 1'b1;
        repeat (4) tick();
        total += 3;
        if (bubble_cnt !== (PERF ? 32'd3 : 32'd0)) begin bad++; $display("FAIL bubble3 got=%0d want=%0d", bubble_cnt, PERF ? 3 : 0); end
        if (s_bubble_cnt !== (PERF ? 3'd3 : 3'd0)) begin bad++; $display("FAIL sat_bubble3 got=%0d want=%0d", s_bubble_cnt, PERF ? 3 : 0); end
        if (stall_cnt !== (PERF ? 32'd10 : 32'd0)) begin bad++; $display("FAIL stall_hold got=%0d want=%0d", stall_cnt, PERF ? 10 : 0); end
    endtask

    task automatic test_rst_in_skid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hE0; in_ctrl = 8'h55;
        tick();
        in_data = 32'hF0;
        tick();
        in_valid = 1'b0;
        total += 1;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_pre_skid got=%0b want=0", in_ready); end
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        total += 6;
        if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_skid_valid got=%0b want=0", out_valid); end
        if (out_data !== 32'h0)   begin bad++; $display("FAIL rst_skid_data got=%h want=0", out_data); end
        if (out_ctrl !== 8'h0)    begin bad++; $display("FAIL rst_skid_ctrl got=%h want=0", out_ctrl); end
        if (in_ready !== 1'b1)    begin bad++; $display("FAIL rst_skid_ready got=%0b want=1", in_ready); end
        if (stall_cnt !== 32'h0)  begin bad++; $display("FAIL rst_skid_stall got=%0d want=0", stall_cnt); end
        if (bubble_cnt !== 32'h0) begin bad++; $display("FAIL rst_skid_bubble got=%0d want=0", bubble_cnt); end
        out_ready = 1'b1;
        tick();
        total += 1;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_skid_discard got=%0b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_counters();
        test_rst_in_skid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
